// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time.
//   clock, reset_L      : clock and asynchronous active-low reset
//   req_valid, change   : change request, amount 0..15 (accepted in IDLE)
//   req_ready           : high only while IDLE
//   coin_valid/five/ack : coin eject handshake (five = 5-unit coin)
//   Remaining           : units still owed on the current request
//   fives, ones         : coin inventory
//   done                : one-cycle pulse, request fully paid
//   NotEnoughChange     : one-cycle pulse (during CHECK), request refused
module change_dispenser #(
  parameter logic [3:0] FIVES_INIT = 4'd3,
  parameter logic [3:0] ONES_INIT  = 4'd4
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       req_valid,
  input  logic [3:0] change,
  output logic       req_ready,
  output logic       coin_valid,
  output logic       coin_five,
  input  logic       coin_ack,
  output logic [3:0] Remaining,
  output logic [3:0] fives,
  output logic [3:0] ones,
  output logic       done,
  output logic       NotEnoughChange
);

  typedef enum logic [1:0] {IDLE, CHECK, EJECT, FINISH} state_e;

  state_e     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] fives_q, fives_d;
  logic [3:0] ones_q, ones_d;

  logic [4:0] f_div, f_use, r1;
  logic       feasible, pick_five;

  // Feasibility uses the same greedy order EJECT follows (fives first), so
  // once accepted the payout can never underflow either counter.
  always_comb begin
    f_div    = {1'b0, rem_q} / 5'd5;
    f_use    = (f_div < {1'b0, fives_q}) ? f_div : {1'b0, fives_q};
    r1       = {1'b0, rem_q} - f_use * 5'd5;
    feasible = (r1 <= {1'b0, ones_q});
  end

  assign pick_five = (rem_q >= 4'd5) && (fives_q != 4'd0);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
      fives_q <= FIVES_INIT;
      ones_q  <= ONES_INIT;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fives_q <= fives_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fives_d = fives_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rem_d   = change;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!feasible) begin
          rem_d   = 4'd0;
          state_d = IDLE;
        end else if (rem_q == 4'd0) begin
          state_d = FINISH;
        end else begin
          state_d = EJECT;
        end
      end
      EJECT: begin
        if (coin_ack) begin
          if (pick_five) begin
            fives_d = fives_q - 4'd1;
            rem_d   = rem_q - 4'd5;
          end else begin
            ones_d  = ones_q - 4'd1;
            rem_d   = rem_q - 4'd1;
          end
          if (rem_d == 4'd0) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign req_ready       = (state_q == IDLE);
  assign coin_valid      = (state_q == EJECT);
  assign coin_five       = (state_q == EJECT) && pick_five;
  assign done            = (state_q == FINISH);
  assign NotEnoughChange = (state_q == CHECK) && !feasible;
  assign Remaining       = rem_q;
  assign fives           = fives_q;
  assign ones            = ones_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset_L, req_valid, coin_ack;
  logic [3:0] change;
  logic       req_ready, coin_valid, coin_five, done, NotEnoughChange;
  logic [3:0] Remaining, fives, ones;

  int checks = 0;
  int errors = 0;
  int mf, mo;        // model inventory
  bit exp_q[$];      // scoreboard: expected coin types, 1 = five

  change_dispenser #(.FIVES_INIT(4'd3), .ONES_INIT(4'd4)) dut (
    .clock(clock), .reset_L(reset_L), .req_valid(req_valid), .change(change),
    .req_ready(req_ready), .coin_valid(coin_valid), .coin_five(coin_five),
    .coin_ack(coin_ack), .Remaining(Remaining), .fives(fives), .ones(ones),
    .done(done), .NotEnoughChange(NotEnoughChange)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic chk_inv(input string tag);
    chk({tag, "_fives"}, {4'b0, fives}, 8'(mf));
    chk({tag, "_ones"},  {4'b0, ones},  8'(mo));
  endtask

  // Called at posedge+1; reset takes effect and is checked before the next edge.
  task automatic do_reset(input string tag);
    reset_L = 1'b0; req_valid = 1'b0; coin_ack = 1'b0;
    mf = 3; mo = 4; exp_q.delete();
    #1;
    chk({tag, "_fives"}, {4'b0, fives}, 8'd3);
    chk({tag, "_ones"},  {4'b0, ones},  8'd4);
    chk({tag, "_rem"},   {4'b0, Remaining}, 8'd0);
    chk({tag, "_cv"},    {7'b0, coin_valid}, 8'd0);
    chk({tag, "_done"},  {7'b0, done}, 8'd0);
    chk({tag, "_nec"},   {7'b0, NotEnoughChange}, 8'd0);
    chk({tag, "_ready"}, {7'b0, req_ready}, 8'd1);
    #2 reset_L = 1'b1;
    step();
  endtask

  task automatic run_req(input int c, input bit stall);
    int fu, r1, rem;
    bit feas, e, first;
    fu   = (c / 5 < mf) ? c / 5 : mf;
    r1   = c - 5 * fu;
    feas = (r1 <= mo);
    if (feas) begin
      repeat (fu) exp_q.push_back(1'b1);
      repeat (r1) exp_q.push_back(1'b0);
    end
    rem = c;
    chk("ready_idle", {7'b0, req_ready}, 8'd1);
    req_valid = 1'b1; change = 4'(c);
    step();
    req_valid = 1'b0; change = 4'hF;
    // CHECK cycle
    chk("nec_check", {7'b0, NotEnoughChange}, {7'b0, !feas});
    chk("cv_check",  {7'b0, coin_valid}, 8'd0);
    chk("rem_latch", {4'b0, Remaining}, 8'(c));
    if (!feas) begin
      step();
      chk("ready_after_rej", {7'b0, req_ready}, 8'd1);
      chk("nec_pulse_end",   {7'b0, NotEnoughChange}, 8'd0);
      chk("rem_cleared",     {4'b0, Remaining}, 8'd0);
      chk("cv_after_rej",    {7'b0, coin_valid}, 8'd0);
      chk_inv("inv_rej");
      return;
    end
    step();
    first = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("coin_valid", {7'b0, coin_valid}, 8'd1);
      chk("coin_five",  {7'b0, coin_five}, {7'b0, e});
      chk("rem_eject",  {4'b0, Remaining}, 8'(rem));
      if (stall && first) begin
        for (int i = 0; i < 5; i++) begin
          coin_ack = 1'b0; req_valid = ~req_valid; change = 4'd1;
          step();
          chk("stall_cv",    {7'b0, coin_valid}, 8'd1);
          chk("stall_five",  {7'b0, coin_five}, {7'b0, e});
          chk("stall_rem",   {4'b0, Remaining}, 8'(rem));
          chk("stall_ready", {7'b0, req_ready}, 8'd0);
        end
        req_valid = 1'b0;
      end
      coin_ack = 1'b1;
      step();
      coin_ack = 1'b0;
      if (e) begin rem -= 5; mf--; end
      else   begin rem -= 1; mo--; end
      first = 1'b0;
    end
    chk("done_pulse", {7'b0, done}, 8'd1);
    chk("cv_finish",  {7'b0, coin_valid}, 8'd0);
    chk("rem_final",  {4'b0, Remaining}, 8'd0);
    step();
    chk("done_end",    {7'b0, done}, 8'd0);
    chk("ready_again", {7'b0, req_ready}, 8'd1);
    chk_inv("inv_done");
  endtask

  initial begin
    reset_L = 1'b0; req_valid = 1'b0; coin_ack = 1'b0; change = 4'd0;
    mf = 3; mo = 4;
    #12;
    chk("rst_fives", {4'b0, fives}, 8'd3);
    chk("rst_ones",  {4'b0, ones},  8'd4);
    chk("rst_rem",   {4'b0, Remaining}, 8'd0);
    chk("rst_cv",    {7'b0, coin_valid}, 8'd0);
    chk("rst_ready", {7'b0, req_ready}, 8'd1);
    @(negedge clock) reset_L = 1'b1;
    step();

    // Reset while a coin is waiting for ack: abandoned, nothing decremented.
    req_valid = 1'b1; change = 4'd7;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_cv", {7'b0, coin_valid}, 8'd1);
    do_reset("mid_rst");

    run_req(7, 1'b0);   // five, one, one -> 2 fives, 2 ones
    run_req(14, 1'b0);  // needs 4 ones with only 2 fives left -> refused
    run_req(0, 1'b0);   // straight to done

    do_reset("rst2");
    run_req(15, 1'b0);  // three fives
    run_req(5, 1'b0);   // fives gone, 4 ones < 5 -> refused
    run_req(3, 1'b0);   // three ones -> ones=1
    run_req(2, 1'b0);   // refused

    do_reset("rst3");
    run_req(14, 1'b0);  // exactly feasible: 2 fives + all 4 ones

    do_reset("rst4");
    run_req(6, 1'b1);   // stalled ack on first coin

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
